// File: rtl/operand_issue.sv
// -----------------------------------------------------------------------------
// operand_issue
//   Issue stage in front of the ALU. Takes decoded instructions, reads the
//   register file (with write-back bypass), tracks outstanding writers in a
//   one-bit-per-register RAW scoreboard, and presents a registered operation
//   to the ALU. The ALU result returns through the write-back port.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   instr_valid/instr_ready    upstream handshake; instr = {cmd, rA, rB, wb_en}
//   issue_valid/issue_ready    downstream handshake for the issued op
//   alu_cmd, inA, inB          registered ALU command and operands
//   issue_dest, issue_wb       destination register and write-enable of the op
//   wb_valid, wb_addr, wb_data register write-back from the ALU
// -----------------------------------------------------------------------------
module operand_issue #(
    parameter int DW   = 8,
    parameter int NREG = 8,
    localparam int AW  = $clog2(NREG),
    localparam int IW  = 2*AW + 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic [IW-1:0] instr,
    output logic          issue_valid,
    input  logic          issue_ready,
    output logic [1:0]    alu_cmd,
    output logic [DW-1:0] inA,
    output logic [DW-1:0] inB,
    output logic [AW-1:0] issue_dest,
    output logic          issue_wb,
    input  logic          wb_valid,
    input  logic [AW-1:0] wb_addr,
    input  logic [DW-1:0] wb_data
);

    logic [NREG-1:0][DW-1:0] regfile_q, regfile_d;
    logic [NREG-1:0]         pending_q, pending_d;
    logic                    issue_valid_q, issue_valid_d;
    logic [1:0]              alu_cmd_q, alu_cmd_d;
    logic [DW-1:0]           in_a_q, in_a_d;
    logic [DW-1:0]           in_b_q, in_b_d;
    logic [AW-1:0]           issue_dest_q, issue_dest_d;
    logic                    issue_wb_q, issue_wb_d;

    // Instruction fields
    logic [1:0]    dec_cmd;
    logic [AW-1:0] dec_ra;
    logic [AW-1:0] dec_rb;
    logic          dec_wb;
    logic          hazard;
    logic          accept;

    assign dec_cmd = instr[IW-1 -: 2];
    assign dec_ra  = instr[2*AW -: AW];
    assign dec_rb  = instr[AW -: AW];
    assign dec_wb  = instr[0];

    // A register being written back this very cycle is no longer a hazard:
    // its value is taken from the write-back bus.
    function automatic logic reg_busy(input logic [NREG-1:0] pend,
                                      input logic [AW-1:0]   r,
                                      input logic            wv,
                                      input logic [AW-1:0]   wa);
        return pend[r] && !(wv && (wa == r));
    endfunction

    function automatic logic [DW-1:0] read_bypass(input logic [NREG-1:0][DW-1:0] rf,
                                                  input logic [AW-1:0]           r,
                                                  input logic                    wv,
                                                  input logic [AW-1:0]           wa,
                                                  input logic [DW-1:0]           wd);
        return (wv && (wa == r)) ? wd : rf[r];
    endfunction

    always_comb begin
        hazard      = reg_busy(pending_q, dec_ra, wb_valid, wb_addr)
                   || reg_busy(pending_q, dec_rb, wb_valid, wb_addr);
        instr_ready = (!issue_valid_q || issue_ready) && !hazard;
        accept      = instr_valid && instr_ready;
    end

    always_comb begin
        regfile_d     = regfile_q;
        pending_d     = pending_q;
        issue_valid_d = issue_valid_q;
        alu_cmd_d     = alu_cmd_q;
        in_a_d        = in_a_q;
        in_b_d        = in_b_q;
        issue_dest_d  = issue_dest_q;
        issue_wb_d    = issue_wb_q;

        if (wb_valid) begin
            regfile_d[wb_addr] = wb_data;
            pending_d[wb_addr] = 1'b0;
        end

        if (accept) begin
            issue_valid_d = 1'b1;
            alu_cmd_d     = dec_cmd;
            in_a_d        = read_bypass(regfile_q, dec_ra, wb_valid, wb_addr, wb_data);
            in_b_d        = read_bypass(regfile_q, dec_rb, wb_valid, wb_addr, wb_data);
            issue_dest_d  = dec_ra;
            issue_wb_d    = dec_wb;
            // Applied after the write-back clear so a new writer stays outstanding.
            if (dec_wb) begin
                pending_d[dec_ra] = 1'b1;
            end
        end else if (issue_ready) begin
            issue_valid_d = 1'b0;
        end
    end

    // Stage register: issue outputs, scoreboard and register file
    always_ff @(posedge clk) begin
        if (reset) begin
            regfile_q     <= '0;
            pending_q     <= '0;
            issue_valid_q <= 1'b0;
            alu_cmd_q     <= '0;
            in_a_q        <= '0;
            in_b_q        <= '0;
            issue_dest_q  <= '0;
            issue_wb_q    <= 1'b0;
        end else begin
            regfile_q     <= regfile_d;
            pending_q     <= pending_d;
            issue_valid_q <= issue_valid_d;
            alu_cmd_q     <= alu_cmd_d;
            in_a_q        <= in_a_d;
            in_b_q        <= in_b_d;
            issue_dest_q  <= issue_dest_d;
            issue_wb_q    <= issue_wb_d;
        end
    end

    assign issue_valid = issue_valid_q;
    assign alu_cmd     = alu_cmd_q;
    assign inA         = in_a_q;
    assign inB         = in_b_q;
    assign issue_dest  = issue_dest_q;
    assign issue_wb    = issue_wb_q;

endmodule

// File: tb/tb_operand_issue.sv
module tb_operand_issue;

    localparam int DW = 8;
    localparam int AW = 3;
    localparam int IW = 9;

    logic          clk = 1'b0;
    logic          reset;
    logic          instr_valid;
    logic          instr_ready;
    logic [IW-1:0] instr;
    logic          issue_valid;
    logic          issue_ready;
    logic [1:0]    alu_cmd;
    logic [DW-1:0] inA;
    logic [DW-1:0] inB;
    logic [AW-1:0] issue_dest;
    logic          issue_wb;
    logic          wb_valid;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;

    int n_vec  = 0;
    int n_miss = 0;

    operand_issue #(.DW(DW), .NREG(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .alu_cmd     (alu_cmd),
        .inA         (inA),
        .inB         (inB),
        .issue_dest  (issue_dest),
        .issue_wb    (issue_wb),
        .wb_valid    (wb_valid),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data)
    );

    always #5 clk = ~clk;

    task automatic chk_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [IW-1:0] mk(input logic [1:0] c, input logic [2:0] ra,
                                         input logic [2:0] rb, input logic w);
        return {c, ra, rb, w};
    endfunction

    task automatic wb(input logic [2:0] a, input logic [7:0] d);
        wb_valid = 1'b1;
        wb_addr  = a;
        wb_data  = d;
    endtask

    task automatic chk_issue(input string tag, input logic [1:0] c, input logic [7:0] a,
                             input logic [7:0] b, input logic [2:0] dst, input logic w);
        chk_vec({tag, ".valid"}, issue_valid, 1);
        chk_vec({tag, ".cmd"},   alu_cmd, c);
        chk_vec({tag, ".inA"},   inA, a);
        chk_vec({tag, ".inB"},   inB, b);
        chk_vec({tag, ".dest"},  issue_dest, dst);
        chk_vec({tag, ".wb"},    issue_wb, w);
    endtask

    initial begin
        reset       = 1'b1;
        instr_valid = 1'b0;
        instr       = '0;
        issue_ready = 1'b1;
        wb_valid    = 1'b0;
        wb_addr     = '0;
        wb_data     = '0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        chk_vec("rst.valid", issue_valid, 0);
        chk_vec("rst.cmd",   alu_cmd, 0);
        chk_vec("rst.inA",   inA, 0);
        chk_vec("rst.inB",   inB, 0);
        chk_vec("rst.dest",  issue_dest, 0);
        chk_vec("rst.wb",    issue_wb, 0);
        chk_vec("rst.ready", instr_ready, 1);

        // T1: basic issue
        wb(3'd2, 8'h15); tick();
        wb(3'd3, 8'h2A); tick();
        wb_valid = 1'b0;
        instr_valid = 1'b1;
        instr = mk(2'b00, 3'd2, 3'd3, 1'b1);
        #1 chk_vec("t1.ready", instr_ready, 1);
        tick();
        instr_valid = 1'b0;
        chk_issue("t1", 2'b00, 8'h15, 8'h2A, 3'd2, 1'b1);

        // T2: RAW stall on r2 until its write-back, then bypass
        instr_valid = 1'b1;
        instr = mk(2'b01, 3'd2, 3'd3, 1'b0);
        #1 chk_vec("t2.stall0", instr_ready, 0);
        tick();
        chk_vec("t2.drain", issue_valid, 0);
        chk_vec("t2.stall1", instr_ready, 0);
        tick();
        chk_vec("t2.stall2", instr_ready, 0);
        wb(3'd2, 8'h3F);
        #1 chk_vec("t2.wbready", instr_ready, 1);
        tick();
        wb_valid = 1'b0;
        instr_valid = 1'b0;
        chk_issue("t2", 2'b01, 8'h3F, 8'h2A, 3'd2, 1'b0);

        // T3: backpressure holds the op and blocks upstream
        issue_ready = 1'b0;
        instr_valid = 1'b1;
        instr = mk(2'b11, 3'd3, 3'd3, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1 chk_vec("t3.ready", instr_ready, 0);
            chk_vec("t3.cmd_hold", alu_cmd, 2'b01);
            chk_vec("t3.inA_hold", inA, 8'h3F);
            chk_vec("t3.vld_hold", issue_valid, 1);
            tick();
        end
        issue_ready = 1'b1;
        #1 chk_vec("t3.release", instr_ready, 1);
        tick();
        chk_issue("t3a", 2'b11, 8'h2A, 8'h2A, 3'd3, 1'b0);
        instr = mk(2'b10, 3'd2, 3'd3, 1'b0);
        #1 chk_vec("t3.b2b_ready", instr_ready, 1);
        tick();
        chk_issue("t3b", 2'b10, 8'h3F, 8'h2A, 3'd2, 1'b0);
        instr_valid = 1'b0;
        tick();
        chk_vec("t3.idle", issue_valid, 0);

        // T4: same-edge clear and set of pending[4]; set must win
        instr_valid = 1'b1;
        instr = mk(2'b00, 3'd4, 3'd1, 1'b1);
        tick();
        wb(3'd4, 8'h44);
        instr = mk(2'b01, 3'd4, 3'd1, 1'b1);
        #1 chk_vec("t4.wbready", instr_ready, 1);
        tick();
        wb_valid = 1'b0;
        chk_issue("t4", 2'b01, 8'h44, 8'h00, 3'd4, 1'b1);
        instr = mk(2'b00, 3'd4, 3'd0, 1'b0);
        #1 chk_vec("t4.rA_pend", instr_ready, 0);
        instr = mk(2'b00, 3'd0, 3'd4, 1'b0);
        #1 chk_vec("t4.rB_pend", instr_ready, 0);
        instr_valid = 1'b0;
        wb(3'd4, 8'h55); tick();
        wb_valid = 1'b0;
        instr = mk(2'b00, 3'd0, 3'd4, 1'b0);
        #1 chk_vec("t4.cleared", instr_ready, 1);

        // T5: reset in flight with pending[5] set
        instr_valid = 1'b1;
        instr = mk(2'b11, 3'd5, 3'd5, 1'b1);
        tick();
        instr_valid = 1'b0;
        chk_vec("t5.pre_valid", issue_valid, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_vec("t5.valid", issue_valid, 0);
        chk_vec("t5.cmd",   alu_cmd, 0);
        chk_vec("t5.inA",   inA, 0);
        chk_vec("t5.inB",   inB, 0);
        chk_vec("t5.dest",  issue_dest, 0);
        chk_vec("t5.wb",    issue_wb, 0);
        instr = mk(2'b00, 3'd5, 3'd5, 1'b0);
        #1 chk_vec("t5.pend_clr", instr_ready, 1);
        instr_valid = 1'b1;
        instr = mk(2'b00, 3'd2, 3'd4, 1'b0);
        tick();
        instr_valid = 1'b0;
        chk_issue("t5.rf", 2'b00, 8'h00, 8'h00, 3'd2, 1'b0);

        // T6: rA == rB
        wb(3'd7, 8'h80); tick();
        wb_valid = 1'b0;
        instr_valid = 1'b1;
        instr = mk(2'b10, 3'd7, 3'd7, 1'b0);
        tick();
        chk_issue("t6", 2'b10, 8'h80, 8'h80, 3'd7, 1'b0);
        #1 chk_vec("t6.no_pend", instr_ready, 1);
        instr_valid = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
